bus_xfer_seq: RTL and testbench

Bus-transfer sequencer that sits directly upstream of the bus-attached registers and counters on the shared tristate `DATA_WIDTH` data bus. It accepts one transfer command at a time from the control unit over a valid/ready handshake. It then generates the per-device CS/OE/WE strobes that those devices sample on the rising clock edge. The command moves a word device-to-device, reads a device into a response register, or writes an immediate word into a device. It guarantees one-driver-at-a-time bus ownership with a turnaround cycle between transfers.

---
 rtl/bus_xfer_seq.sv | 176 +++++++++++++++++
 tb/tb_bus_xfer_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_seq.sv
// Bus-transfer sequencer: takes one MOVE/READ/WRITE command at a time and
// drives registered CS/OE/WE strobes plus the shared tristate data bus so
// that only one driver owns the bus, with a turnaround cycle after each
// command.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bus_xfer_seq #(
    parameter int NDEV = 4,
    parameter int SELW = $clog2(NDEV),
    parameter int DW   = `DATA_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [SELW-1:0] cmd_src,
    input  logic [SELW-1:0] cmd_dst,
    input  logic [DW-1:0]   cmd_wdata,
    inout  wire  [DW-1:0]   data,
    output logic [NDEV-1:0] CS,
    output logic [NDEV-1:0] OE,
    output logic [NDEV-1:0] WE,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [DW-1:0]   rsp_data,
    output logic [15:0]     xfer_count
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_TURN} state_t;

    localparam logic [1:0]  OP_MOVE  = 2'd0;
    localparam logic [1:0]  OP_READ  = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd2;
    localparam logic [1:0]  OP_RSVD  = 2'd3;
    localparam logic [SELW:0] NDEV_W = (SELW+1)'(NDEV);

    state_t            r_state;
    state_t            w_nxt_state;
    logic [1:0]        r_op;
    logic [SELW-1:0]   r_src;
    logic [SELW-1:0]   r_dst;
    logic [DW-1:0]     r_wdata;
    logic [NDEV-1:0]   r_cs;
    logic [NDEV-1:0]   r_oe;
    logic [NDEV-1:0]   r_we;
    logic              r_drv;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DW-1:0]     r_rsp_data;
    logic [15:0]       r_xfer_count;

    logic              w_accept;
    logic              w_illegal;
    logic [1:0]        w_op;
    logic [SELW-1:0]   w_src;
    logic [SELW-1:0]   w_dst;
    logic [NDEV-1:0]   w_cs_nxt;
    logic [NDEV-1:0]   w_oe_nxt;
    logic [NDEV-1:0]   w_we_nxt;
    logic              w_drv_nxt;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_illegal = (cmd_op == OP_RSVD)
                    || ({1'b0, cmd_src} >= NDEV_W)
                    || ({1'b0, cmd_dst} >= NDEV_W)
                    || ((cmd_op == OP_MOVE) && (cmd_src == cmd_dst));

    // Next-state decode; rejected commands skip straight to the turnaround.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_nxt_state = w_illegal ? S_TURN : S_SETUP;
            S_SETUP: w_nxt_state = S_XFER;
            S_XFER:  w_nxt_state = S_TURN;
            S_TURN:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Strobe values for the state being entered, so the outputs come
    // straight from flops; the accept edge uses the incoming command fields.
    always_comb begin
        w_op      = r_op;
        w_src     = r_src;
        w_dst     = r_dst;
        w_cs_nxt  = '0;
        w_oe_nxt  = '0;
        w_we_nxt  = '0;
        w_drv_nxt = 1'b0;
        if (r_state == S_IDLE) begin
            w_op  = cmd_op;
            w_src = cmd_src;
            w_dst = cmd_dst;
        end
        if ((w_nxt_state == S_SETUP) || (w_nxt_state == S_XFER)) begin
            for (int i = 0; i < NDEV; i++) begin
                if ((w_op != OP_WRITE) && (w_src == SELW'(i))) begin
                    w_cs_nxt[i] = 1'b1;
                    w_oe_nxt[i] = 1'b1;
                end
                if ((w_op != OP_READ) && (w_dst == SELW'(i))) begin
                    w_cs_nxt[i] = 1'b1;
                    if (w_nxt_state == S_XFER) w_we_nxt[i] = 1'b1;
                end
            end
            w_drv_nxt = (w_op == OP_WRITE);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_nxt_state;
    end

    // Command capture at the handshake; fields are ignored outside IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= cmd_op;
            r_src   <= cmd_src;
            r_dst   <= cmd_dst;
            r_wdata <= cmd_wdata;
        end
    end

    // Registered strobes and bus-drive enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs  <= '0;
            r_oe  <= '0;
            r_we  <= '0;
            r_drv <= 1'b0;
        end else begin
            r_cs  <= w_cs_nxt;
            r_oe  <= w_oe_nxt;
            r_we  <= w_we_nxt;
            r_drv <= w_drv_nxt;
        end
    end

    // Completion pulse, error flag, captured word and transfer counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= '0;
            r_xfer_count <= '0;
        end else begin
            r_rsp_valid <= (w_nxt_state == S_TURN);
            r_rsp_err   <= w_accept && w_illegal;
            if (r_state == S_XFER) begin
                r_rsp_data   <= data;
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

    assign data       = r_drv ? r_wdata : {DW{1'bz}};
    assign cmd_ready  = (r_state == S_IDLE);
    assign CS         = r_cs;
    assign OE         = r_oe;
    assign WE         = r_we;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_data   = r_rsp_data;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Bench for bus_xfer_seq: a directed command table, random commands checked
// against a command-level model of the bus devices, then reset-mid-transfer
// and back-to-back/counter-wrap sequences.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_bus_xfer_seq;
    localparam int NDEV = 4;
    localparam int SELW = 2;
    localparam int DW   = `DATA_WIDTH;
    localparam logic [1:0] OP_MOVE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_RSVD = 2'd3;

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [SELW-1:0] cmd_src;
    logic [SELW-1:0] cmd_dst;
    logic [DW-1:0]   cmd_wdata;
    wire  [DW-1:0]   data;
    logic [NDEV-1:0] CS, OE, WE;
    logic            rsp_valid, rsp_err;
    logic [DW-1:0]   rsp_data;
    logic [15:0]     xfer_count;

    int checks   = 0;
    int failures = 0;

    bus_xfer_seq #(.NDEV(NDEV), .SELW(SELW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_wdata(cmd_wdata),
        .data(data), .CS(CS), .OE(OE), .WE(WE), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_data(rsp_data), .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus devices: drive when selected+output-enabled, capture on write strobe.
    logic [DW-1:0] dev_mem [NDEV] = '{default: '0};
    logic          tb_drv;
    logic [DW-1:0] tb_val;
    always_comb begin
        tb_drv = 1'b0;
        tb_val = '0;
        for (int i = 0; i < NDEV; i++)
            if (CS[i] && OE[i]) begin tb_drv = 1'b1; tb_val = dev_mem[i]; end
    end
    assign data = tb_drv ? tb_val : {DW{1'bz}};
    always @(posedge clk)
        for (int i = 0; i < NDEV; i++)
            if (CS[i] && WE[i]) dev_mem[i] <= data;

    // Command-level reference model.
    logic [DW-1:0] m_mem [NDEV] = '{default: '0};
    logic [15:0]   m_cnt = '0;
    logic [DW-1:0] m_rsp = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (reset) chk("oe_onehot", 32'($countones(OE) <= 1), 1);

    // Issue one command at a negedge in IDLE; checks every cycle until IDLE again.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                           input logic [DW-1:0] wd, output logic t_err,
                           output logic [DW-1:0] t_rsp, output logic [15:0] t_cnt);
        logic            legal;
        logic [NDEV-1:0] e_cs, e_oe, e_we;
        logic [DW-1:0]   val;
        int              n;
        legal = (op != OP_RSVD) && !(op == OP_MOVE && src == dst)
                && (int'(src) < NDEV) && (int'(dst) < NDEV);
        e_cs = '0; e_oe = '0; e_we = '0;
        if (legal) begin
            if (op != OP_WRITE) begin e_cs[src] = 1'b1; e_oe[src] = 1'b1; end
            if (op != OP_READ)  begin e_cs[dst] = 1'b1; e_we[dst] = 1'b1; end
        end
        val = (op == OP_WRITE) ? wd : m_mem[src];
        n   = legal ? 4 : 2;
        t_err = 1'b0; t_rsp = '0; t_cnt = '0;
        chk("ready_before", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = ~wd;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            if (k == n - 1) begin
                if (legal) begin
                    m_cnt = m_cnt + 16'd1;
                    m_rsp = val;
                    if (op != OP_READ) m_mem[dst] = val;
                end
                chk("rsp_err", 32'(rsp_err), 32'(!legal));
                t_err = rsp_err; t_rsp = rsp_data; t_cnt = xfer_count;
            end
            chk("cs", 32'(CS), 32'((legal && k <= 2) ? e_cs : '0));
            chk("oe", 32'(OE), 32'((legal && k <= 2) ? e_oe : '0));
            chk("we", 32'(WE), 32'((legal && k == 2) ? e_we : '0));
            chk("cmd_ready", 32'(cmd_ready), 32'(k == n));
            chk("rsp_valid", 32'(rsp_valid), 32'(k == n - 1));
            chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
            chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
        end
        for (int i = 0; i < NDEV; i++) chk("dev_mem", 32'(dev_mem[i]), 32'(m_mem[i]));
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [1:0]    src;
        logic [1:0]    dst;
        logic [DW-1:0] wd;
        logic          exp_err;
        logic [DW-1:0] exp_rsp;
        logic [15:0]   exp_cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic          e;
        logic [DW-1:0] r;
        logic [15:0]   c;
        int            ncomp, accepts;
        int            ccyc [3];
        logic [15:0]   ccnt [3];

        tbl[0] = '{OP_WRITE, 2'd0, 2'd1, 8'hBF, 1'b0, 8'hBF, 16'd1};
        tbl[1] = '{OP_WRITE, 2'd0, 2'd2, 8'hAD, 1'b0, 8'hAD, 16'd2};
        tbl[2] = '{OP_READ,  2'd2, 2'd2, 8'h00, 1'b0, 8'hAD, 16'd3};
        tbl[3] = '{OP_MOVE,  2'd2, 2'd0, 8'h00, 1'b0, 8'hAD, 16'd4};
        tbl[4] = '{OP_MOVE,  2'd3, 2'd3, 8'h11, 1'b1, 8'hAD, 16'd4};
        tbl[5] = '{OP_RSVD,  2'd0, 2'd1, 8'h22, 1'b1, 8'hAD, 16'd4};
        tbl[6] = '{OP_READ,  2'd0, 2'd3, 8'h00, 1'b0, 8'hAD, 16'd5};
        tbl[7] = '{OP_READ,  2'd1, 2'd0, 8'h00, 1'b0, 8'hBF, 16'd6};
        tbl[8] = '{OP_WRITE, 2'd3, 2'd1, 8'h00, 1'b0, 8'h00, 16'd7};
        tbl[9] = '{OP_READ,  2'd1, 2'd1, 8'h00, 1'b0, 8'h00, 16'd8};

        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_cs", 32'(CS), 0);
        chk("rst_oe", 32'(OE), 0);
        chk("rst_we", 32'(WE), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_count", 32'(xfer_count), 0);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].wd, e, r, c);
            chk("tbl_err", 32'(e), 32'(tbl[i].exp_err));
            chk("tbl_rsp", 32'(r), 32'(tbl[i].exp_rsp));
            chk("tbl_cnt", 32'(c), 32'(tbl[i].exp_cnt));
        end

        // Random commands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    DW'($urandom), e, r, c);
        end

        // Reset during XFER of a WRITE.
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_src = 2'd0; cmd_dst = 2'd3; cmd_wdata = 8'h67;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_we_xfer", 32'(WE), 32'h8);
        #2 reset = 1'b0;
        #1;
        chk("mid_cs", 32'(CS), 0);
        chk("mid_oe", 32'(OE), 0);
        chk("mid_we", 32'(WE), 0);
        chk("mid_ready", 32'(cmd_ready), 1);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rsp_data", 32'(rsp_data), 0);
        chk("mid_count", 32'(xfer_count), 0);
        m_cnt = '0; m_rsp = '0;
        @(negedge clk);
        reset = 1'b1;
        run_cmd(OP_WRITE, 2'd0, 2'd3, 8'h23, e, r, c);
        chk("post_rst_rsp", 32'(r), 32'h23);
        chk("post_rst_cnt", 32'(c), 1);

        // Back-to-back WRITEs with cmd_valid held, counter preloaded near wrap.
        force dut.r_xfer_count = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.r_xfer_count;
        @(negedge clk);
        chk("preload", 32'(xfer_count), 32'hFFFE);
        cmd_op = OP_WRITE; cmd_src = 2'd0; cmd_dst = 2'd1; cmd_wdata = 8'h5A;
        ncomp = 0; accepts = 0;
        for (int cyc = 0; cyc < 30 && ncomp < 3; cyc++) begin
            if (rsp_valid) begin
                ccyc[ncomp] = cyc;
                ccnt[ncomp] = xfer_count;
                ncomp++;
            end
            cmd_valid = (accepts < 3);
            if (cmd_valid && cmd_ready) accepts++;
            if (ncomp < 3) @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("b2b_completions", 32'(ncomp), 3);
        if (ncomp == 3) begin
            chk("b2b_space0", 32'(ccyc[1] - ccyc[0]), 4);
            chk("b2b_space1", 32'(ccyc[2] - ccyc[1]), 4);
            chk("wrap_cnt0", 32'(ccnt[0]), 32'hFFFF);
            chk("wrap_cnt1", 32'(ccnt[1]), 32'h0000);
            chk("wrap_cnt2", 32'(ccnt[2]), 32'h0001);
        end
        repeat (3) @(negedge clk);
        chk("b2b_idle_ready", 32'(cmd_ready), 1);
        chk("b2b_dev1", 32'(dev_mem[1]), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
